// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide RAM plus UART/IO window serving the core memory bus
module ram_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_ready,
    output logic        tx_overflow,
    output logic        sim_done
);
    localparam int          PW     = $clog2(TX_DEPTH);
    localparam logic [PW:0] DEPTH  = (PW+1)'(TX_DEPTH);
    localparam logic [PW:0] MARGIN = (PW+1)'(FULL_MARGIN);

    logic [7:0]                ram_q [2**RAM_ADDR_WIDTH];
    logic [7:0]                fifo_q [TX_DEPTH];
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [7:0]                ram_rd_q;
    logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]               count_q, count_d;
    logic [7:0]                io_rd_q, io_rd_d, rx_q, rx_d;
    logic                      src_ram_q, src_ram_d;
    logic                      rx_v_q, rx_v_d;
    logic                      ovf_q, ovf_d, halt_q, halt_d, done_q, done_d;
    logic                      is_ram, is_io, sel_tx, sel_ctl, rd_en;
    logic                      push_req, push, pop, rx_take, rx_clr;
    logic                      unused_bits;

    assign unused_bits    = ^mem_a[31:18];
    assign uart_tx_valid  = rdy && count_q != '0;
    assign uart_tx_data   = fifo_q[rptr_q];
    assign io_buffer_full = (DEPTH - count_q) <= MARGIN;
    assign uart_rx_ready  = rst && rdy && !rx_v_q;
    assign mem_din        = src_ram_q ? ram_rd_q : io_rd_q;
    assign tx_overflow    = ovf_q;
    assign sim_done       = done_q;

    // Address decode, FIFO/RX handshakes and next-state for all control registers
    always_comb begin
        ram_idx   = mem_a[RAM_ADDR_WIDTH-1:0];
        is_ram    = !mem_a[17];
        is_io     = mem_a[17:16] == 2'b11;
        sel_tx    = is_io && mem_a[15:0] == 16'h0000;
        sel_ctl   = is_io && mem_a[15:0] == 16'h0004;
        rd_en     = rdy && !mem_wr;
        pop       = uart_tx_valid && uart_tx_ready;
        push_req  = rdy && mem_wr && sel_tx;
        push      = push_req && (count_q < DEPTH || pop);
        rx_take   = uart_rx_valid && uart_rx_ready;
        rx_clr    = rd_en && sel_tx;
        wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
        count_d   = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        ovf_d     = ovf_q || (push_req && !push);
        halt_d    = halt_q || (rdy && mem_wr && sel_ctl);
        done_d    = done_q || (rdy && halt_q && count_q == '0);
        rx_v_d    = rx_clr ? 1'b0 : rx_take ? 1'b1 : rx_v_q;
        rx_d      = rx_take ? uart_rx_data : rx_q;
        src_ram_d = rd_en ? is_ram : src_ram_q;
        io_rd_d   = !rd_en ? io_rd_q :
                    sel_tx ? (rx_v_q ? rx_q : 8'h00) :
                    sel_ctl ? {6'b0, rx_v_q, io_buffer_full} : 8'h00;
    end

    // RAM and FIFO storage carry no reset; RAM read is registered with a read enable
    always_ff @(posedge clk) begin
        if (rdy && mem_wr && is_ram) ram_q[ram_idx] <= mem_dout;
        if (rd_en && is_ram) ram_rd_q <= ram_q[ram_idx];
        if (push) fifo_q[wptr_q] <= mem_dout;
    end

    // Control state; every _d already holds its value when rdy is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            io_rd_q   <= 8'h00;
            src_ram_q <= 1'b0;
            rx_q      <= 8'h00;
            rx_v_q    <= 1'b0;
            ovf_q     <= 1'b0;
            halt_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            io_rd_q   <= io_rd_d;
            src_ram_q <= src_ram_d;
            rx_q      <= rx_d;
            rx_v_q    <= rx_v_d;
            ovf_q     <= ovf_d;
            halt_q    <= halt_d;
            done_q    <= done_d;
        end
    end
endmodule
